// File: rtl/modulator.sv
// QPSK symbol mapper: serialises each accepted data word into Gray-mapped
// signed I/Q symbols, MSB pair first, one symbol per clock.
module modulator #(
    parameter int unsigned       SIZE_INPUT_BIT  = 8,
    parameter int unsigned       SIZE_OUTPUT_BIT = 32,
    parameter logic signed [31:0] AMPLITUDE      = 32'sd1518500249
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]    i_data,
    input  logic                         i_valid_input,
    output logic                         o_ready,
    output logic [2*SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                         o_valid_output
);

    localparam int unsigned NUM_SYM = SIZE_INPUT_BIT / 2;
    localparam int unsigned CNT_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int unsigned DATA_W  = 2 * SIZE_OUTPUT_BIT;

    localparam logic [CNT_W-1:0]                LAST_SYM = CNT_W'(NUM_SYM - 1);
    localparam logic signed [SIZE_OUTPUT_BIT-1:0] AMP_POS = SIZE_OUTPUT_BIT'(AMPLITUDE);
    localparam logic signed [SIZE_OUTPUT_BIT-1:0] AMP_NEG = -AMP_POS;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SIZE_INPUT_BIT-1:0] shift_q, shift_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic                      last_sym;
    logic                      accept;

    // Gray map of one bit pair: b1 selects I sign, b0 selects Q sign.
    function automatic logic [DATA_W-1:0] map_symbol(input logic [1:0] bits);
        logic signed [SIZE_OUTPUT_BIT-1:0] i_val;
        logic signed [SIZE_OUTPUT_BIT-1:0] q_val;
        i_val = bits[1] ? AMP_NEG : AMP_POS;
        q_val = bits[0] ? AMP_NEG : AMP_POS;
        return {i_val, q_val};
    endfunction

    // Ready when idle or presenting the final symbol of the current word.
    assign last_sym = (state_q == ST_SEND) && (cnt_q == LAST_SYM);
    assign o_ready  = !i_reset && ((state_q == ST_IDLE) || last_sym);
    assign accept   = i_valid_input && o_ready;

    assign o_data         = data_q;
    assign o_valid_output = (state_q == ST_SEND);

    // State and datapath registers; reset discards any in-flight word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
        end
    end

    // Next-state: load a new word, advance to the next pair, or fall idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    data_d  = map_symbol(i_data[SIZE_INPUT_BIT-1 -: 2]);
                    shift_d = i_data << 2;
                end
            end
            ST_SEND: begin
                if (last_sym) begin
                    if (accept) begin
                        cnt_d   = '0;
                        data_d  = map_symbol(i_data[SIZE_INPUT_BIT-1 -: 2]);
                        shift_d = i_data << 2;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        data_d  = '0;
                        shift_d = '0;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    data_d  = map_symbol(shift_q[SIZE_INPUT_BIT-1 -: 2]);
                    shift_d = shift_q << 2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_modulator.sv
// Directed bench for the QPSK mapper: per-cycle vector table plus a
// hand-written reset-mid-word sequence.
module tb_modulator;

    localparam logic signed [31:0] AMP     = 32'sd1518500249;
    localparam logic signed [31:0] AMP_NEG = -32'sd1518500249;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid_input = 1'b0;
    logic        o_ready;
    logic [63:0] o_data;
    logic        o_valid_output;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       exp_ready;
        logic       exp_valid;
        logic [1:0] exp_sym;
    } vec_t;

    vec_t vecs[$];

    modulator #(
        .SIZE_INPUT_BIT (8),
        .SIZE_OUTPUT_BIT(32),
        .AMPLITUDE      (32'sd1518500249)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_data        (i_data),
        .i_valid_input (i_valid_input),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid_output(o_valid_output)
    );

    always #5 i_clk = ~i_clk;

    // Expected {I,Q} for a symbol pair, zero when idle.
    function automatic logic [63:0] exp_data(input logic valid, input logic [1:0] sym);
        logic [31:0] iv;
        logic [31:0] qv;
        if (!valid) return 64'd0;
        iv = sym[1] ? AMP_NEG : AMP;
        qv = sym[0] ? AMP_NEG : AMP;
        return {iv, qv};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [7:0] data,
                       input logic rdy, input logic ov, input logic [1:0] sym);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data;
        v.exp_ready = rdy; v.exp_valid = ov; v.exp_sym = sym;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset held for 4 cycles, then one idle cycle.
        for (int k = 0; k < 4; k++) add(1, 0, 8'h00, 0, 0, 2'b00);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        // Single word 00_01_10_11.
        add(0, 1, 8'h1B, 1, 1, 2'b00);
        add(0, 0, 8'h00, 0, 1, 2'b01);
        add(0, 0, 8'h00, 0, 1, 2'b10);
        add(0, 0, 8'h00, 0, 1, 2'b11);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        // Busy drop: 8'hFF offered during symbols 0..2 is ignored.
        add(0, 1, 8'h1B, 1, 1, 2'b00);
        add(0, 1, 8'hFF, 0, 1, 2'b01);
        add(0, 1, 8'hFF, 0, 1, 2'b10);
        add(0, 1, 8'hFF, 0, 1, 2'b11);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        // Streaming 8'h00 then 8'hFF, valid held high.
        add(0, 1, 8'h00, 1, 1, 2'b00);
        add(0, 1, 8'hFF, 0, 1, 2'b00);
        add(0, 1, 8'hFF, 0, 1, 2'b00);
        add(0, 1, 8'hFF, 0, 1, 2'b00);
        add(0, 1, 8'hFF, 1, 1, 2'b11);
        add(0, 0, 8'h00, 0, 1, 2'b11);
        add(0, 0, 8'h00, 0, 1, 2'b11);
        add(0, 0, 8'h00, 0, 1, 2'b11);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        // Gap: 8'hA5, three idle cycles, 8'h5A.
        add(0, 1, 8'hA5, 1, 1, 2'b10);
        add(0, 0, 8'h00, 0, 1, 2'b10);
        add(0, 0, 8'h00, 0, 1, 2'b01);
        add(0, 0, 8'h00, 0, 1, 2'b01);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        add(0, 0, 8'h00, 1, 0, 2'b00);
        add(0, 1, 8'h5A, 1, 1, 2'b01);
        add(0, 0, 8'h00, 0, 1, 2'b01);
        add(0, 0, 8'h00, 0, 1, 2'b10);
        add(0, 0, 8'h00, 0, 1, 2'b10);
        add(0, 0, 8'h00, 1, 0, 2'b00);

        // Each row: drive after falling edge, check ready, then outputs after rising edge.
        foreach (vecs[i]) begin
            @(negedge i_clk);
            i_reset       = vecs[i].rst;
            i_valid_input = vecs[i].vld;
            i_data        = vecs[i].data;
            #1;
            check($sformatf("row%0d ready", i), 64'(o_ready), 64'(vecs[i].exp_ready));
            @(posedge i_clk);
            #1;
            check($sformatf("row%0d valid", i), 64'(o_valid_output), 64'(vecs[i].exp_valid));
            check($sformatf("row%0d data", i), o_data,
                  exp_data(vecs[i].exp_valid, vecs[i].exp_sym));
        end

        // Reset mid-word: accept 8'hFF, reset while symbol 1 is shown.
        begin
            bit seen;
            @(negedge i_clk);
            i_valid_input = 1'b1;
            i_data        = 8'hFF;
            @(negedge i_clk);
            i_valid_input = 1'b0;
            i_data        = 8'h00;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                if (o_valid_output) seen = 1'b1;
                else @(negedge i_clk);
            end
            check("midrst first_symbol_seen", 64'(seen), 64'd1);
            check("midrst sym0", o_data, exp_data(1'b1, 2'b11));
            @(negedge i_clk);
            check("midrst sym1", o_data, exp_data(1'b1, 2'b11));
            i_reset = 1'b1;
            #1;
            check("midrst ready_in_reset", 64'(o_ready), 64'd0);
            @(posedge i_clk);
            #1;
            check("midrst valid_after", 64'(o_valid_output), 64'd0);
            check("midrst data_after", o_data, 64'd0);
            @(negedge i_clk);
            i_reset = 1'b0;
            #1;
            check("midrst ready_release", 64'(o_ready), 64'd1);
            for (int c = 0; c < 4; c++) begin
                @(posedge i_clk);
                #1;
                check($sformatf("midrst quiet%0d", c), 64'(o_valid_output), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
